// File: rtl/arbitro_salida_pkg.sv
// Shared constants for the transaction-layer arbiter and its receive-side drain.
package arbitro_salida_pkg;

   // One-hot main FSM state encodings.
   localparam logic [3:0] ST_RESET  = 4'b0001;
   localparam logic [3:0] ST_INIT   = 4'b0010;
   localparam logic [3:0] ST_IDLE   = 4'b0100;
   localparam logic [3:0] ST_ACTIVE = 4'b1000;

   localparam int NUM_FIFOS      = 4;
   localparam int DEFAULT_DATA_W = 10;

   // True only for the exact one-hot codes in which draining is allowed.
   // RESET and any malformed encoding return 0.
   function automatic logic state_enabled(input logic [3:0] st);
      return (st == ST_INIT) || (st == ST_IDLE) || (st == ST_ACTIVE);
   endfunction

endpackage

// File: rtl/arbitro_salida_rr4.sv
// Combinational 4-way rotating-priority grant.
// The search starts at ptr and wraps; the first requester found wins.
// gnt is one-hot or zero, and gnt_id is 0 whenever nothing is granted.
module arbitro_rr4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   input  logic       en,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id
);

   logic       found;
   logic [1:0] idx;

   // Scan from ptr modulo 4 and pick the first requesting FIFO.
   always_comb begin
      found  = 1'b0;
      gnt    = '0;
      gnt_id = '0;
      idx    = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            gnt_id = idx;
         end
      end
      if (en && found) begin
         gnt[gnt_id] = 1'b1;
      end else begin
         gnt_id = 2'd0;
      end
   end

endmodule

// File: rtl/arbitro_salida.sv
// Drains the four purple output FIFOs round-robin into one registered stream.
//
// Output handshake: valid_out qualifies data_out and grant_id for exactly the
// cycle it is high; there is no ready. The consumer throttles us through
// almost_full_out, which while low guarantees room for the two words that
// can already be in flight (pop -> pend -> output).
module arbitro_salida
   import arbitro_salida_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [3:0]        state,
   input  logic              empty0_morado,
   input  logic              empty1_morado,
   input  logic              empty2_morado,
   input  logic              empty3_morado,
   input  logic [DATA_W-1:0] data0_morado,
   input  logic [DATA_W-1:0] data1_morado,
   input  logic [DATA_W-1:0] data2_morado,
   input  logic [DATA_W-1:0] data3_morado,
   input  logic              almost_full_out,
   output logic              pop0,
   output logic              pop1,
   output logic              pop2,
   output logic              pop3,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        grant_id,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2,
   output logic [CNT_W-1:0]  cnt3
);

   logic              en;
   logic [3:0]        req;
   logic [3:0]        gnt;
   logic [1:0]        gnt_id;
   logic [1:0]        rr_ptr;
   logic              pend_valid;
   logic [1:0]        pend_id;
   logic [DATA_W-1:0] sel_data;
   logic [CNT_W-1:0]  cnt_q [NUM_FIFOS];

   // reset_L is folded into en so the pops drop combinationally during reset.
   assign en  = reset_L & state_enabled(state) & ~almost_full_out;
   assign req = ~{empty3_morado, empty2_morado, empty1_morado, empty0_morado};

   arbitro_rr4 u_rr4 (
      .req    (req),
      .ptr    (rr_ptr),
      .en     (en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign {pop3, pop2, pop1, pop0} = gnt;

   // FIFO read data arrives the cycle after the pop; select the pending source.
   always_comb begin
      sel_data = data0_morado;
      case (pend_id)
         2'd0: sel_data = data0_morado;
         2'd1: sel_data = data1_morado;
         2'd2: sel_data = data2_morado;
         2'd3: sel_data = data3_morado;
         default: sel_data = data0_morado;
      endcase
   end

   // Rotate the pointer past the FIFO just popped and remember the pending pop.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         rr_ptr     <= 2'd0;
         pend_valid <= 1'b0;
         pend_id    <= 2'd0;
      end else begin
         pend_valid <= |gnt;
         if (|gnt) begin
            rr_ptr  <= gnt_id + 2'd1;
            pend_id <= gnt_id;
         end
      end
   end

   // Capture the pending word, tag its source and count it. Data and grant_id
   // hold between words so only valid_out drops when nothing is pending.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         grant_id  <= 2'd0;
         for (int i = 0; i < NUM_FIFOS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         valid_out <= pend_valid;
         if (pend_valid) begin
            data_out         <= sel_data;
            grant_id         <= pend_id;
            cnt_q[pend_id]   <= cnt_q[pend_id] + 1'b1;
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_arbitro_salida.sv
// Bench for arbitro_salida: bench-side FIFOs, a reference model computed from
// the round-robin / two-cycle-latency rules, and a scoreboard of due words.
module tb_arbitro_salida;
   import arbitro_salida_pkg::*;

   localparam int DW  = 10;
   localparam int CW  = 2;
   localparam int E_W = 32 + 2 + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_L;
   logic [3:0]    state;
   logic          almost_full;
   logic [3:0]    empty_v;
   logic [DW-1:0] fifo_rd [4];

   logic          pop0, pop1, pop2, pop3;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [1:0]    grant_id;
   logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

   arbitro_salida #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk             (clk),
      .reset_L         (reset_L),
      .state           (state),
      .empty0_morado   (empty_v[0]),
      .empty1_morado   (empty_v[1]),
      .empty2_morado   (empty_v[2]),
      .empty3_morado   (empty_v[3]),
      .data0_morado    (fifo_rd[0]),
      .data1_morado    (fifo_rd[1]),
      .data2_morado    (fifo_rd[2]),
      .data3_morado    (fifo_rd[3]),
      .almost_full_out (almost_full),
      .pop0            (pop0),
      .pop1            (pop1),
      .pop2            (pop2),
      .pop3            (pop3),
      .data_out        (data_out),
      .valid_out       (valid_out),
      .grant_id        (grant_id),
      .cnt0            (cnt0),
      .cnt1            (cnt1),
      .cnt2            (cnt2),
      .cnt3            (cnt3)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0]  fq [4][$];     // contents of each bench FIFO
   logic [E_W-1:0] exp_q [$];     // {due_cycle, source id, word}
   int             m_ptr;
   logic           m_vout;
   logic [DW-1:0]  m_dout;
   logic [1:0]     m_gid;
   int             m_cnt [4];
   int             cyc;
   int             checks = 0;
   int             errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Which FIFO the round-robin rule says to pop now, or -1 for none.
   function automatic int exp_pop_id();
      if (!reset_L || almost_full) return -1;
      if (!(state inside {ST_INIT, ST_IDLE, ST_ACTIVE})) return -1;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_ptr + k) % 4;
         if (fq[i].size() != 0) return i;
      end
      return -1;
   endfunction

   // ---------------- driver ----------------
   // Called at the negedge with inputs already set; returns at the next negedge.
   task automatic step();
      int             pid;
      logic [3:0]     exp_v;
      logic [3:0]     popv;
      logic [E_W-1:0] e;
      logic [31:0]    due;
      for (int i = 0; i < 4; i++) empty_v[i] = (fq[i].size() == 0);
      #1;
      pid   = exp_pop_id();
      exp_v = 4'b0;
      if (pid >= 0) exp_v[pid] = 1'b1;
      popv  = {pop3, pop2, pop1, pop0};
      check_val("pop", 32'(popv), 32'(exp_v));

      @(posedge clk);
      #1;
      if (!reset_L) begin
         m_ptr  = 0;
         exp_q.delete();
         m_vout = 1'b0;
         m_dout = '0;
         m_gid  = 2'd0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (pid >= 0) begin
         due = 32'(cyc + 2);
         exp_q.push_back({due, 2'(pid), fq[pid][0]});
         m_ptr = (pid + 1) % 4;
      end
      // Bench FIFOs react to what the DUT actually popped.
      for (int i = 0; i < 4; i++) begin
         if (popv[i] && fq[i].size() != 0) fifo_rd[i] = fq[i].pop_front();
      end
      cyc++;
      if (reset_L) begin
         if (exp_q.size() != 0 && exp_q[0][E_W-1 -: 32] == 32'(cyc)) begin
            e      = exp_q.pop_front();
            m_vout = 1'b1;
            m_gid  = e[DW+1:DW];
            m_dout = e[DW-1:0];
            m_cnt[m_gid] = (m_cnt[m_gid] + 1) % (1 << CW);
         end else begin
            m_vout = 1'b0;
         end
      end

      @(negedge clk);
      check_val("valid_out", 32'(valid_out), 32'(m_vout));
      check_val("data_out", 32'(data_out), 32'(m_dout));
      check_val("grant_id", 32'(grant_id), 32'(m_gid));
      check_val("cnt0", 32'(cnt0), 32'(m_cnt[0]));
      check_val("cnt1", 32'(cnt1), 32'(m_cnt[1]));
      check_val("cnt2", 32'(cnt2), 32'(m_cnt[2]));
      check_val("cnt3", 32'(cnt3), 32'(m_cnt[3]));
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < 4; i++) fq[i].delete();
   endtask

   task automatic fill_all(input int n);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < n; j++) fq[i].push_back(DW'($urandom_range(0, (1 << DW) - 1)));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      cyc         = 0;
      m_ptr       = 0;
      m_vout      = 1'b0;
      m_dout      = '0;
      m_gid       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         m_cnt[i]   = 0;
         fifo_rd[i] = '0;
      end
      reset_L     = 1'b0;
      state       = ST_ACTIVE;
      almost_full = 1'b0;
      empty_v     = 4'hF;
      @(negedge clk);

      // Reset with every FIFO non-empty: nothing pops, outputs are cleared.
      fill_all(3);
      run(2);

      // Single source in INIT.
      clear_fifos();
      fq[1].push_back(10'h05A);
      state   = ST_INIT;
      reset_L = 1'b1;
      run(4);

      // Rotation over all four FIFOs.
      state = ST_ACTIVE;
      fill_all(2);
      run(10);

      // Backpressure, then release.
      fill_all(4);
      run(3);
      almost_full = 1'b1;
      run(4);
      almost_full = 1'b0;
      run(4);

      // RESET state and a malformed encoding both block popping.
      state = ST_RESET;
      run(3);
      state = 4'b0110;
      run(3);
      state = ST_IDLE;
      run(20);

      // Counter wrap: five words from FIFO0 after a fresh reset.
      clear_fifos();
      reset_L = 1'b0;
      run(1);
      reset_L = 1'b1;
      for (int j = 0; j < 5; j++) fq[0].push_back(DW'(j + 1));
      run(8);

      // Reset the cycle after a pop discards the in-flight word.
      fq[0].push_back(10'h3C3);
      fq[0].push_back(10'h111);
      run(1);
      reset_L = 1'b0;
      run(1);
      reset_L = 1'b1;
      run(4);

      // Randomised traffic, states, backpressure and occasional resets.
      for (int t = 0; t < 400; t++) begin
         for (int p = 0; p < 2; p++) begin
            int f;
            f = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1 && fq[f].size() < 8)
               fq[f].push_back(DW'($urandom_range(0, (1 << DW) - 1)));
         end
         case ($urandom_range(0, 9))
            0:       state = 4'($urandom_range(0, 15));
            1:       state = ST_RESET;
            2, 3:    state = ST_INIT;
            4, 5:    state = ST_IDLE;
            default: state = ST_ACTIVE;
         endcase
         almost_full = ($urandom_range(0, 4) == 0);
         reset_L     = ($urandom_range(0, 99) != 0);
         step();
      end

      // Drain whatever is left.
      reset_L     = 1'b1;
      state       = ST_ACTIVE;
      almost_full = 1'b0;
      run(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
